// File: rtl/regfile_pkg.sv
// Shared types for the register file and its writeback path.
package regfile_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int RA_W = 5;

  typedef logic [RA_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0] word_t;

  typedef struct packed {
    reg_addr_t addr;
    word_t     data;
  } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester found scanning from ptr upward, wrapping at N-1.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx
);

  localparam int IW = $clog2(N);

  // Priority scan starting at ptr; at most one grant bit is ever set.
  always_comb begin
    int  idx;
    logic found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        found        = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/regfile_wb_sched.sv
// Writeback scheduler for the single regfile write port, plus a pending-producer
// scoreboard that flags read hazards and write-after-write issue conflicts to decode.
module regfile_wb_sched
  import regfile_pkg::*;
#(
  parameter int NSRC      = 3,
  parameter bit ZERO_HARD = 1'b1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic      [NSRC-1:0]  src_valid,
  output logic      [NSRC-1:0]  src_ready,
  input  reg_addr_t [NSRC-1:0]  src_addr,
  input  word_t     [NSRC-1:0]  src_data,
  output logic                  we3,
  output reg_addr_t             wa3,
  output word_t                 wd3,
  input  logic                  iss_valid,
  input  reg_addr_t             iss_rd,
  output logic                  iss_ready,
  input  reg_addr_t             ra1,
  input  reg_addr_t             ra2,
  output logic                  hazard1,
  output logic                  hazard2,
  output logic                  idle
);

  localparam int PW = $clog2(NSRC);

  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]   gnt_idx;
  logic [NSRC-1:0] gnt;
  logic            xfer;
  logic            drop;
  logic            iss_fire;
  wb_req_t         req_g;

  logic            we3_q, we3_d;
  wb_req_t         wr_q, wr_d;
  logic [NREG-1:0] pend_q, pend_d;

  rr_arbiter #(.N(NSRC)) u_arb (
    .req     (src_valid),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Grants are forced low during reset so nothing transfers while the scoreboard is cleared.
  assign src_ready = gnt & {NSRC{rstn}};
  assign xfer      = |src_ready;
  assign req_g     = '{addr: src_addr[gnt_idx], data: src_data[gnt_idx]};
  assign drop      = ZERO_HARD && (req_g.addr == '0);

  // Issue readiness ignores a same-cycle clear of iss_rd to keep this path short.
  assign iss_ready = (ZERO_HARD && (iss_rd == '0)) || !pend_q[iss_rd];
  assign iss_fire  = iss_valid && iss_ready && (!ZERO_HARD || (iss_rd != '0));

  // The we3 term covers the cycle after pending clears but before the regfile commits.
  assign hazard1 = (!ZERO_HARD || (ra1 != '0)) && (pend_q[ra1] || (we3_q && (wr_q.addr == ra1)));
  assign hazard2 = (!ZERO_HARD || (ra2 != '0)) && (pend_q[ra2] || (we3_q && (wr_q.addr == ra2)));
  assign idle    = !(|pend_q) && !we3_q;

  assign we3 = we3_q;
  assign wa3 = wr_q.addr;
  assign wd3 = wr_q.data;

  // Next-state: arbiter pointer, write-port staging and scoreboard set/clear (set wins).
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    we3_d    = 1'b0;
    wr_d     = wr_q;
    pend_d   = pend_q;
    if (xfer) begin
      rr_ptr_d = (gnt_idx == PW'(NSRC - 1)) ? '0 : gnt_idx + PW'(1);
      pend_d[req_g.addr] = 1'b0;
      if (!drop) begin
        we3_d = 1'b1;
        wr_d  = req_g;
      end
    end
    if (iss_fire) pend_d[iss_rd] = 1'b1;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_ptr_q <= '0;
      we3_q    <= 1'b0;
      wr_q     <= '0;
      pend_q   <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      we3_q    <= we3_d;
      wr_q     <= wr_d;
      pend_q   <= pend_d;
    end
  end

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Scoreboard bench for regfile_wb_sched: a behavioural model predicts grants, hazards and
// regfile writes; a separate monitor pops expected writes whenever we3 is seen.
module tb_regfile_wb_sched;

  localparam int NS = 3;
  localparam bit ZH = 1'b1;

  logic                 clk = 1'b0;
  logic                 rstn;
  logic [NS-1:0]        src_valid;
  logic [NS-1:0]        src_ready;
  logic [NS-1:0][4:0]   src_addr;
  logic [NS-1:0][31:0]  src_data;
  logic                 we3;
  logic [4:0]           wa3;
  logic [31:0]          wd3;
  logic                 iss_valid;
  logic [4:0]           iss_rd;
  logic                 iss_ready;
  logic [4:0]           ra1, ra2;
  logic                 hazard1, hazard2, idle;

  regfile_wb_sched #(.NSRC(NS), .ZERO_HARD(ZH)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .src_addr  (src_addr),
    .src_data  (src_data),
    .we3       (we3),
    .wa3       (wa3),
    .wd3       (wd3),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .iss_ready (iss_ready),
    .ra1       (ra1),
    .ra2       (ra2),
    .hazard1   (hazard1),
    .hazard2   (hazard2),
    .idle      (idle)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          a;
    logic [31:0] d;
    int          c;
  } wr_t;

  wr_t expq[$];
  int  n_chk  = 0;
  int  n_fail = 0;

  // reference model state
  bit  pend[32];
  int  ptr;
  bit  infl_v;
  int  infl_a;
  int  last_g;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    foreach (pend[i]) pend[i] = 1'b0;
    ptr    = 0;
    infl_v = 1'b0;
    infl_a = 0;
    last_g = -1;
    expq.delete();
  endtask

  // One clock cycle: check combinational outputs against the model mid-cycle,
  // advance the model, then move to just after the next rising edge.
  task automatic step();
    int          g;
    int          idx;
    int          a;
    logic [NS-1:0] er;
    bit          eir, h1, h2, idl;
    @(negedge clk);
    g = -1;
    for (int k = 0; k < NS; k++) begin
      idx = (ptr + k) % NS;
      if (g < 0 && src_valid[idx]) g = idx;
    end
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    eir = (ZH && iss_rd == 0) || !pend[iss_rd];
    h1  = (ra1 != 0) && (pend[ra1] || (infl_v && infl_a == int'(ra1)));
    h2  = (ra2 != 0) && (pend[ra2] || (infl_v && infl_a == int'(ra2)));
    idl = !infl_v;
    foreach (pend[i]) if (pend[i]) idl = 1'b0;
    chk("src_ready", src_ready, er);
    chk("iss_ready", iss_ready, eir);
    chk("hazard1", hazard1, h1);
    chk("hazard2", hazard2, h2);
    chk("idle", idle, idl);
    infl_v = 1'b0;
    last_g = g;
    if (g >= 0) begin
      ptr     = (g + 1) % NS;
      a       = int'(src_addr[g]);
      pend[a] = 1'b0;
      if (!(ZH && a == 0)) begin
        infl_v = 1'b1;
        infl_a = a;
        expq.push_back('{a: a, d: src_data[g], c: cyc + 1});
      end
    end
    if (iss_valid && eir && !(ZH && iss_rd == 0)) pend[iss_rd] = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every we3 pulse must match the oldest expected write, on the predicted cycle.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (rstn === 1'b1) begin
        if (we3 === 1'b1) begin
          if (expq.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL we3_unexpected: got we3=1 wa3=%0h expected no write (cycle %0d)", wa3, cyc);
          end else begin
            e = expq.pop_front();
            chk("wa3", wa3, e.a);
            chk("wd3", wd3, e.d);
            chk("wr_cycle", cyc, e.c);
          end
        end else if (expq.size() != 0 && expq[0].c <= cyc) begin
          n_chk++;
          n_fail++;
          $display("FAIL we3_missing: got we3=%0b expected write to %0d (cycle %0d)", we3, expq[0].a, cyc);
          void'(expq.pop_front());
        end
      end
    end
  end

  task automatic idle_inputs();
    src_valid = '0;
    iss_valid = 1'b0;
    iss_rd    = '0;
    ra1       = '0;
    ra2       = '0;
  endtask

  initial begin
    model_reset();
    // async reset asserted before any clock edge, sources all requesting
    rstn      = 1'b0;
    idle_inputs();
    src_valid = 3'b111;
    src_addr  = '{5'd3, 5'd2, 5'd1};
    src_data  = '{32'h3, 32'h2, 32'h1};
    #1;
    chk("rst_we3", we3, 1'b0);
    chk("rst_src_ready", src_ready, 3'b000);
    chk("rst_idle", idle, 1'b1);
    chk("rst_wa3", wa3, 5'd0);
    chk("rst_wd3", wd3, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;

    // round-robin: all three valid for six cycles, each re-presents new data once granted
    for (int i = 0; i < NS; i++) begin
      src_addr[i] = 5'(16 + i);
      src_data[i] = 32'hA000_0000 + i;
    end
    src_valid = 3'b111;
    for (int n = 0; n < 6; n++) begin
      step();
      if (last_g >= 0) begin
        src_addr[last_g] = 5'(20 + n);
        src_data[last_g] = 32'hB000_0000 + n;
      end
    end
    src_valid = '0;
    step();

    // single source
    src_valid   = 3'b001;
    src_addr[0] = 5'd1;
    src_data[0] = 32'hFFFF_FFFF;
    step();
    src_valid = '0;
    step();

    // scoreboard: issue rd=2, hazard until one cycle after the write
    iss_valid = 1'b1; iss_rd = 5'd2; ra1 = 5'd2; ra2 = 5'd1;
    step();
    step();
    src_valid   = 3'b010;
    src_addr[1] = 5'd2;
    src_data[1] = 32'hDDDD_DDDD;
    step();
    src_valid = '0;
    iss_valid = 1'b0;
    step();
    step();
    step();

    // set/clear collision on register 5
    iss_valid   = 1'b1; iss_rd = 5'd5;
    src_valid   = 3'b001;
    src_addr[0] = 5'd5;
    src_data[0] = 32'h5555_5555;
    step();
    iss_valid = 1'b0; src_valid = '0; ra1 = 5'd5;
    step();
    step();

    // zero register
    src_valid   = 3'b100;
    src_addr[2] = 5'd0;
    src_data[2] = 32'hEEEE_EEEE;
    iss_valid   = 1'b1; iss_rd = 5'd0; ra1 = 5'd0; ra2 = 5'd0;
    step();
    src_valid = '0; iss_valid = 1'b0;
    step();

    // randomized traffic with a mid-run asynchronous reset
    for (int n = 0; n < 400; n++) begin
      if (n == 200) begin
        rstn      = 1'b0;
        src_valid = 3'b111;
        #1;
        chk("midrst_we3", we3, 1'b0);
        chk("midrst_src_ready", src_ready, 3'b000);
        chk("midrst_idle", idle, 1'b1);
        model_reset();
        @(posedge clk);
        #1;
        rstn = 1'b1;
      end
      for (int i = 0; i < NS; i++) begin
        if (!src_valid[i] || last_g == i) begin
          src_valid[i] = ($urandom_range(0, 9) < 6);
          src_addr[i]  = 5'($urandom_range(0, 7));
          src_data[i]  = $urandom;
        end
      end
      iss_valid = ($urandom_range(0, 2) == 0);
      iss_rd    = 5'($urandom_range(0, 7));
      ra1       = 5'($urandom_range(0, 7));
      ra2       = 5'($urandom_range(0, 7));
      step();
    end

    idle_inputs();
    repeat (4) step();
    chk("queue_empty", expq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
